// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default frame constants
// and the parity helper used by both directions of the link.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_BITS_DEF     = 8;
    localparam int TICKS_PER_BIT_DEF = 16;
    localparam int MAX_DATA_BITS     = 8;

    // Narrower words are passed zero-extended; the padding does not change the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: one-entry holding register in front of a start/data/parity/stop
// serialiser paced by the shared baud oversampling Tick.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = DATA_BITS_DEF,
    parameter int TICKS_PER_BIT  = TICKS_PER_BIT_DEF,
    parameter int STOP_BIT_TICKS = 16,
    parameter int PARITY_EN      = 0,
    parameter int PARITY_ODD     = 0
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Tick,
    input  logic                 TxValid,
    input  logic [DATA_BITS-1:0] TxData,
    output logic                 TxReady,
    output logic                 Tx,
    output logic                 TxBusy,
    output logic                 TxDone
);

    localparam int MAX_TICKS = (TICKS_PER_BIT > STOP_BIT_TICKS) ? TICKS_PER_BIT : STOP_BIT_TICKS;
    localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_BIT_TICKS - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic              ODD_SEL   = (PARITY_ODD != 0);

    tx_state_t              stateReg;
    logic                   txReg;
    logic                   txDoneReg;
    logic                   bufFullReg;
    logic [DATA_BITS-1:0]   bufReg;
    logic [DATA_BITS-1:0]   shiftReg;
    logic                   parityReg;
    logic [TICK_W-1:0]      tickCnt;
    logic [BIT_W-1:0]       bitCnt;

    logic [MAX_DATA_BITS-1:0] bufPadded;
    logic                     bufParity;
    logic                     stopEnd;
    logic                     loadNow;

    always_comb begin
        bufPadded                = '0;
        bufPadded[DATA_BITS-1:0] = bufReg;
    end

    assign bufParity = calc_parity(bufPadded, ODD_SEL);

    // A finished stop period with a queued byte reloads on the same edge, so frames abut.
    assign stopEnd = (stateReg == STOP) && Tick && (tickCnt == STOP_LAST);
    assign loadNow = bufFullReg && ((stateReg == IDLE) || stopEnd);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            stateReg   <= IDLE;
            txReg      <= 1'b1;
            txDoneReg  <= 1'b0;
            bufFullReg <= 1'b0;
            bufReg     <= '0;
            shiftReg   <= '0;
            parityReg  <= 1'b0;
            tickCnt    <= '0;
            bitCnt     <= '0;
        end else begin
            txDoneReg <= 1'b0;

            if (TxValid && !bufFullReg) begin
                bufReg     <= TxData;
                bufFullReg <= 1'b1;
            end

            case (stateReg)
                IDLE: begin
                    txReg   <= 1'b1;
                    tickCnt <= '0;
                    bitCnt  <= '0;
                end

                START: begin
                    if (Tick) begin
                        if (tickCnt == BIT_LAST) begin
                            tickCnt  <= '0;
                            txReg    <= shiftReg[0];
                            stateReg <= DATA;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (Tick) begin
                        if (tickCnt == BIT_LAST) begin
                            tickCnt <= '0;
                            if (bitCnt == DATA_LAST) begin
                                if (PARITY_EN != 0) begin
                                    txReg    <= parityReg;
                                    stateReg <= PARITY;
                                end else begin
                                    txReg    <= 1'b1;
                                    stateReg <= STOP;
                                end
                            end else begin
                                shiftReg <= shiftReg >> 1;
                                txReg    <= shiftReg[1];
                                bitCnt   <= bitCnt + 1'b1;
                            end
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (Tick) begin
                        if (tickCnt == BIT_LAST) begin
                            tickCnt  <= '0;
                            txReg    <= 1'b1;
                            stateReg <= STOP;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (Tick) begin
                        if (tickCnt == STOP_LAST) begin
                            tickCnt   <= '0;
                            txDoneReg <= 1'b1;
                            txReg     <= 1'b1;
                            stateReg  <= IDLE;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                end

                default: begin
                    stateReg <= IDLE;
                    txReg    <= 1'b1;
                    tickCnt  <= '0;
                    bitCnt   <= '0;
                end
            endcase

            // Load overrides the per-state updates; the Tick on this edge is not counted.
            if (loadNow) begin
                shiftReg   <= bufReg;
                parityReg  <= bufParity;
                bufFullReg <= 1'b0;
                txReg      <= 1'b0;
                tickCnt    <= '0;
                bitCnt     <= '0;
                stateReg   <= START;
            end
        end
    end

    assign Tx      = txReg;
    assign TxReady = !bufFullReg;
    assign TxBusy  = (stateReg != IDLE);
    assign TxDone  = txDoneReg;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a line monitor rebuilds each frame from Tx and
// Tick, and table vectors plus hand sequences compare it with hand-computed frames.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       resetN;
    logic       tick;
    logic [2:0] txValid;
    logic [7:0] txData [3];
    logic [2:0] txReady, tx, txBusy, txDone;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Instance 0: no parity; 1: even parity; 2: odd parity.
    uart_transmitter #(.DATA_BITS(8), .TICKS_PER_BIT(16), .STOP_BIT_TICKS(16),
                       .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .Clock(clk), .ResetN(resetN), .Tick(tick), .TxValid(txValid[0]), .TxData(txData[0]),
        .TxReady(txReady[0]), .Tx(tx[0]), .TxBusy(txBusy[0]), .TxDone(txDone[0]));

    uart_transmitter #(.DATA_BITS(8), .TICKS_PER_BIT(16), .STOP_BIT_TICKS(16),
                       .PARITY_EN(1), .PARITY_ODD(0)) dutEven (
        .Clock(clk), .ResetN(resetN), .Tick(tick), .TxValid(txValid[1]), .TxData(txData[1]),
        .TxReady(txReady[1]), .Tx(tx[1]), .TxBusy(txBusy[1]), .TxDone(txDone[1]));

    uart_transmitter #(.DATA_BITS(8), .TICKS_PER_BIT(16), .STOP_BIT_TICKS(16),
                       .PARITY_EN(1), .PARITY_ODD(1)) dutOdd (
        .Clock(clk), .ResetN(resetN), .Tick(tick), .TxValid(txValid[2]), .TxData(txData[2]),
        .TxReady(txReady[2]), .Tx(tx[2]), .TxBusy(txBusy[2]), .TxDone(txDone[2]));

    initial begin
        tick = 1'b0;
        forever begin
            repeat (15) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    typedef struct {
        int          dut;
        logic [10:0] bits;
        logic        glitch;
        logic        doneAtEnd;
        int          startCyc;
        int          endCyc;
    } rec_t;

    rec_t        frames[$];
    int          cyc = 0;
    logic        lastTick = 1'b0;
    logic        active [3] = '{1'b0, 1'b0, 1'b0};
    logic        prevTx [3] = '{1'b1, 1'b1, 1'b1};
    logic        glitch [3];
    logic [10:0] cap    [3];
    int          j        [3] = '{0, 0, 0};
    int          startCyc [3] = '{0, 0, 0};
    int          doneCount[3] = '{0, 0, 0};

    // Tx after the edge that carried tick number n of a frame shows slot n/16.
    always @(negedge clk) begin
        logic hadTick;
        hadTick  = lastTick;
        lastTick = tick;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            int nb;
            int bi;
            nb = (d == 0) ? 10 : 11;
            if (!resetN) begin
                active[d] = 1'b0;
                prevTx[d] = 1'b1;
            end else begin
                if (txDone[d]) doneCount[d]++;
                if (active[d]) begin
                    if (hadTick) j[d]++;
                    if (j[d] == 16 * nb) begin
                        frames.push_back('{d, cap[d], glitch[d], txDone[d], startCyc[d], cyc});
                        active[d] = 1'b0;
                    end else begin
                        bi = j[d] / 16;
                        if (hadTick && (j[d] % 16 == 0)) cap[d][bi] = tx[d];
                        else if (tx[d] !== cap[d][bi]) glitch[d] = 1'b1;
                    end
                end
                if (!active[d] && prevTx[d] && !tx[d]) begin
                    active[d]   = 1'b1;
                    j[d]        = 0;
                    cap[d]      = '0;
                    glitch[d]   = 1'b0;
                    startCyc[d] = cyc;
                end
                prevTx[d] = tx[d];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input int d, input logic [7:0] b);
        logic r;
        int   n;
        txValid[d] = 1'b1;
        txData[d]  = b;
        n = 0;
        while (1) begin
            r = txReady[d];
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 6000) begin
                chk("send_timeout", 32'(n), 32'(0));
                break;
            end
        end
        txValid[d] = 1'b0;
        $display("send dut%0d byte 0x%02h at cycle %0d", d, b, cyc);
    endtask

    task automatic waitJ(input int n);
        int k;
        k = 0;
        while (!(active[0] && j[0] >= n) && k < 4000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 4000) chk("waitJ_timeout", 32'(k), 32'(0));
    endtask

    task automatic getFrame(output rec_t r);
        int k;
        k = 0;
        while (frames.size() == 0 && k < 4000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (frames.size() == 0) begin
            chk("frame_timeout", 32'(k), 32'(0));
            r = '{-1, 11'h7FF, 1'b1, 1'b0, 0, 0};
        end else begin
            r = frames.pop_front();
            $display("frame dut%0d bits 0x%03h glitch %0d done %0d start %0d end %0d",
                     r.dut, r.bits, r.glitch, r.doneAtEnd, r.startCyc, r.endCyc);
        end
    endtask

    typedef struct {
        int          dut;
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    initial begin
        vec_t        vecs [7];
        rec_t        r1, r2, r3;
        logic [7:0]  acc;
        logic [10:0] accFrame;
        int          accCyc;
        int          dc;
        int          n;
        logic        rdy;

        // Slot i of the frame = line level in bit period i (start, data LSB first, parity, stop).
        vecs[0] = '{0, 8'h81, 11'h302};
        vecs[1] = '{0, 8'h55, 11'h2AA};
        vecs[2] = '{1, 8'h07, 11'h60E};
        vecs[3] = '{2, 8'h07, 11'h40E};
        vecs[4] = '{0, 8'h00, 11'h200};
        vecs[5] = '{0, 8'hFF, 11'h3FE};
        vecs[6] = '{0, 8'h5A, 11'h2B4};

        resetN  = 1'b0;
        txValid = '0;
        for (int d = 0; d < 3; d++) txData[d] = '0;
        acc    = '0;
        accCyc = -1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx",    32'(tx[0]),      32'(1));
        chk("rst_ready", 32'(txReady[0]), 32'(1));
        chk("rst_busy",  32'(txBusy[0]),  32'(0));
        chk("rst_done",  32'(txDone[0]),  32'(0));
        resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_tx",   32'(tx[0]),      32'(1));
        chk("idle_busy", 32'(txBusy[0]),  32'(0));

        // Back-to-back frames and one-edge load latency
        send(0, 8'hA3);
        chk("lat_tx_hold", 32'(tx[0]), 32'(1));
        @(posedge clk);
        #1;
        chk("lat_tx_fall", 32'(tx[0]),     32'(0));
        chk("lat_busy",    32'(txBusy[0]), 32'(1));
        waitJ(16 * 3);
        send(0, 8'h0F);
        chk("b2b_ready_low", 32'(txReady[0]), 32'(0));
        waitJ(16 * 9 + 4);
        chk("b2b_ready_stop", 32'(txReady[0]), 32'(0));
        getFrame(r1);
        chk("b2b_f1_bits",   32'(r1.bits),      32'(11'h346));
        chk("b2b_f1_glitch", 32'(r1.glitch),    32'(0));
        chk("b2b_f1_done",   32'(r1.doneAtEnd), 32'(1));
        chk("b2b_ready_after", 32'(txReady[0]), 32'(1));
        getFrame(r2);
        chk("b2b_f2_bits",   32'(r2.bits),      32'(11'h21E));
        chk("b2b_f2_glitch", 32'(r2.glitch),    32'(0));
        chk("b2b_no_gap",    32'(r2.startCyc),  32'(r1.endCyc));
        chk("b2b_done_gap",  32'(r2.endCyc - r1.endCyc), 32'(2560));
        repeat (2) @(posedge clk);
        #1;

        // Handshake: TxData wobbles while TxReady is low; only the accept-edge byte goes out
        send(0, 8'h3C);
        send(0, 8'hC4);
        chk("hs_ready_low", 32'(txReady[0]), 32'(0));
        txValid[0] = 1'b1;
        n = 0;
        while (n < 6000) begin
            txData[0] = 8'($urandom);
            rdy = txReady[0];
            @(posedge clk);
            #1;
            if (rdy) begin
                acc    = txData[0];
                accCyc = cyc;
                break;
            end
            n++;
        end
        txValid[0] = 1'b0;
        if (n >= 6000) chk("hs_accept_timeout", 32'(n), 32'(0));
        accFrame = {1'b0, 1'b1, acc, 1'b0};
        $display("hs accepted byte 0x%02h at cycle %0d", acc, accCyc);
        getFrame(r1);
        chk("hs_f1_bits", 32'(r1.bits), 32'(11'h278));
        chk("hs_accept_cycle", 32'(accCyc), 32'(r1.endCyc));
        getFrame(r2);
        chk("hs_f2_bits", 32'(r2.bits), 32'(11'h388));
        getFrame(r3);
        chk("hs_f3_bits",   32'(r3.bits),   32'(accFrame));
        chk("hs_f3_glitch", 32'(r3.glitch), 32'(0));
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset during data bit 3 (0xB7 bit 3 is 0) with a byte queued
        send(0, 8'hB7);
        waitJ(16 * 4 + 5);
        send(0, 8'h44);
        chk("mr_ready_low", 32'(txReady[0]), 32'(0));
        chk("mr_pre_tx",    32'(tx[0]),      32'(0));
        dc = doneCount[0];
        #2 resetN = 1'b0;
        #1;
        chk("mr_tx",    32'(tx[0]),      32'(1));
        chk("mr_ready", 32'(txReady[0]), 32'(1));
        chk("mr_busy",  32'(txBusy[0]),  32'(0));
        chk("mr_done",  32'(txDone[0]),  32'(0));
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("mr_no_frame", 32'(frames.size()), 32'(0));
        chk("mr_no_done",  32'(doneCount[0] - dc), 32'(0));
        chk("mr_idle_busy", 32'(txBusy[0]), 32'(0));
        chk("mr_idle_tx",   32'(tx[0]),     32'(1));

        // Table vectors: single frames, parity variants, loopback bytes
        for (int v = 0; v < 7; v++) begin
            int d;
            d  = vecs[v].dut;
            dc = doneCount[d];
            send(d, vecs[v].data);
            getFrame(r1);
            chk($sformatf("vec%0d_dut", v),    32'(r1.dut),       32'(d));
            chk($sformatf("vec%0d_bits", v),   32'(r1.bits),      32'(vecs[v].frame));
            chk($sformatf("vec%0d_glitch", v), 32'(r1.glitch),    32'(0));
            chk($sformatf("vec%0d_done", v),   32'(r1.doneAtEnd), 32'(1));
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_count", v), 32'(doneCount[d] - dc), 32'(1));
            chk($sformatf("vec%0d_busy", v),  32'(txBusy[d]),  32'(0));
            chk($sformatf("vec%0d_tx", v),    32'(tx[d]),      32'(1));
            chk($sformatf("vec%0d_ready", v), 32'(txReady[d]), 32'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
